// File: rtl/wb_arbiter_pkg.sv
// Shared types and helpers for the write-back arbiter: FU result and buffered entry formats,
// the source enumeration, and ROB-age arithmetic.
package wb_arbiter_pkg;

   localparam int TAG_W   = 5;
   localparam int PD_W    = 7;
   localparam int DATA_W  = 32;
   localparam int NUM_SRC = 3;

   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  robTag;
      logic [PD_W-1:0]   pd;
      logic              we;
      logic [DATA_W-1:0] data;
   } fu_result_t;

   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  robTag;
      logic [PD_W-1:0]   pd;
      logic              we;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   typedef enum logic [1:0] {
      SRC_ALU = 2'd0,
      SRC_BR  = 2'd1,
      SRC_MEM = 2'd2
   } src_e;

   // Ages are distances from the ROB head, so the 5-bit subtraction wraps naturally.
   function automatic logic isYounger(input logic [TAG_W-1:0] tag,
                                      input logic [TAG_W-1:0] refTag,
                                      input logic [TAG_W-1:0] robHead);
      logic [TAG_W-1:0] tagAge;
      logic [TAG_W-1:0] refAge;
      tagAge = tag - robHead;
      refAge = refTag - robHead;
      return tagAge > refAge;
   endfunction

   function automatic logic [1:0] srcAdd(input logic [1:0] src, input logic [1:0] step);
      logic [2:0] sum;
      sum = {1'b0, src} + {1'b0, step};
      return (sum >= 3'(NUM_SRC)) ? 2'(sum - 3'(NUM_SRC)) : sum[1:0];
   endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of FU result inputs, flush control and CDB outputs shared by the arbiter and its clients.
interface wb_arbiter_if;
   import wb_arbiter_pkg::*;

   logic              alu_valid;
   logic              b_valid;
   logic              mem_valid;
   logic [TAG_W-1:0]  alu_rob_tag;
   logic [TAG_W-1:0]  b_rob_tag;
   logic [TAG_W-1:0]  mem_rob_tag;
   logic [PD_W-1:0]   alu_pd;
   logic [PD_W-1:0]   b_pd;
   logic [PD_W-1:0]   mem_pd;
   logic              alu_we;
   logic              b_we;
   logic              mem_we;
   logic [DATA_W-1:0] alu_result;
   logic [DATA_W-1:0] b_result;
   logic [DATA_W-1:0] mem_result;
   logic              alu_full;
   logic              b_full;
   logic              mem_full;
   logic              mispredict;
   logic [TAG_W-1:0]  mispredict_tag;
   logic [TAG_W-1:0]  rob_head;
   logic              cdb_valid;
   logic [TAG_W-1:0]  cdb_rob_tag;
   logic [PD_W-1:0]   cdb_pd;
   logic              cdb_we;
   logic [DATA_W-1:0] cdb_data;
   logic              overflow;

   modport master (
      output alu_valid, b_valid, mem_valid,
      output alu_rob_tag, b_rob_tag, mem_rob_tag,
      output alu_pd, b_pd, mem_pd,
      output alu_we, b_we, mem_we,
      output alu_result, b_result, mem_result,
      output mispredict, mispredict_tag, rob_head,
      input  alu_full, b_full, mem_full,
      input  cdb_valid, cdb_rob_tag, cdb_pd, cdb_we, cdb_data, overflow
   );

   modport slave (
      input  alu_valid, b_valid, mem_valid,
      input  alu_rob_tag, b_rob_tag, mem_rob_tag,
      input  alu_pd, b_pd, mem_pd,
      input  alu_we, b_we, mem_we,
      input  alu_result, b_result, mem_result,
      input  mispredict, mispredict_tag, rob_head,
      output alu_full, b_full, mem_full,
      output cdb_valid, cdb_rob_tag, cdb_pd, cdb_we, cdb_data, overflow
   );

endinterface

// File: rtl/wb_arbiter_fifo.sv
// Per-source result buffer with per-entry flush mask. An empty buffer forwards an accepted push
// as its head so a result can be granted in the cycle it arrives.
module wb_fifo
   import wb_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  wb_entry_t        i_pushEntry,
   input  logic             i_grant,
   input  logic             i_flush,
   input  logic [TAG_W-1:0] i_flushTag,
   input  logic [TAG_W-1:0] i_robHead,
   output wb_entry_t        o_head,
   output logic             o_eligible,
   output logic             o_full,
   output logic             o_overflow
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   wb_entry_t        r_mem [DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [CNT_W-1:0] r_count;

   logic      w_empty;
   logic      w_pushAccept;
   logic      w_headPresent;
   logic      w_headDead;
   logic      w_pop;
   wb_entry_t w_stored;

   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign o_full       = (r_count == CNT_W'(DEPTH));
   assign w_empty      = (r_count == '0);
   assign o_overflow   = i_push && o_full;
   assign w_pushAccept = i_push && !o_full &&
                         !(i_flush && isYounger(i_pushEntry.robTag, i_flushTag, i_robHead));
   assign w_stored     = r_mem[r_rdPtr];

   // A head that is already invalid or being flushed this cycle is retired without a grant.
   always_comb begin
      o_head        = w_stored;
      w_headPresent = 1'b0;
      w_headDead    = 1'b0;
      if (!w_empty) begin
         w_headPresent = 1'b1;
         w_headDead    = !w_stored.valid ||
                         (i_flush && isYounger(w_stored.robTag, i_flushTag, i_robHead));
      end else if (w_pushAccept) begin
         o_head        = i_pushEntry;
         w_headPresent = 1'b1;
      end
      o_eligible = w_headPresent && !w_headDead;
      w_pop      = w_headPresent && (w_headDead || i_grant);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i].valid <= 1'b0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (i_flush && isYounger(r_mem[i].robTag, i_flushTag, i_robHead)) begin
               r_mem[i].valid <= 1'b0;
            end
         end
         if (w_pushAccept) begin
            r_mem[r_wrPtr] <= i_pushEntry;
            r_wrPtr        <= nextPtr(r_wrPtr);
         end
         if (w_pop) begin
            r_rdPtr <= nextPtr(r_rdPtr);
         end
         case ({w_pushAccept, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: buffers ALU, branch and memory results and broadcasts one per cycle on the
// CDB under round-robin, discarding results younger than a mispredicted branch.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   wb_arbiter_if.slave bus
);

   fu_result_t         w_fuIn      [NUM_SRC];
   wb_entry_t          w_pushEntry [NUM_SRC];
   wb_entry_t          w_head      [NUM_SRC];
   logic [NUM_SRC-1:0] w_eligible;
   logic [NUM_SRC-1:0] w_full;
   logic [NUM_SRC-1:0] w_overflowPulse;
   logic [NUM_SRC-1:0] w_grant;
   logic               w_anyGrant;
   src_e               w_grantSrc;
   src_e               w_rrPtrNext;
   src_e               r_rrPtr;
   wb_entry_t          r_cdb;
   logic               r_overflow;

   assign w_fuIn[SRC_ALU] = '{valid: bus.alu_valid, robTag: bus.alu_rob_tag, pd: bus.alu_pd,
                              we: bus.alu_we, data: bus.alu_result};
   assign w_fuIn[SRC_BR]  = '{valid: bus.b_valid, robTag: bus.b_rob_tag, pd: bus.b_pd,
                              we: bus.b_we, data: bus.b_result};
   assign w_fuIn[SRC_MEM] = '{valid: bus.mem_valid, robTag: bus.mem_rob_tag, pd: bus.mem_pd,
                              we: bus.mem_we, data: bus.mem_result};

   for (genvar g = 0; g < NUM_SRC; g++) begin : gSrc
      assign w_pushEntry[g] = '{valid: 1'b1, robTag: w_fuIn[g].robTag, pd: w_fuIn[g].pd,
                                we: w_fuIn[g].we, data: w_fuIn[g].data};

      wb_fifo #(
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk         (clk),
         .reset       (reset),
         .i_push      (w_fuIn[g].valid),
         .i_pushEntry (w_pushEntry[g]),
         .i_grant     (w_grant[g]),
         .i_flush     (bus.mispredict),
         .i_flushTag  (bus.mispredict_tag),
         .i_robHead   (bus.rob_head),
         .o_head      (w_head[g]),
         .o_eligible  (w_eligible[g]),
         .o_full      (w_full[g]),
         .o_overflow  (w_overflowPulse[g])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rrPtr <= SRC_ALU;
      end else begin
         r_rrPtr <= w_rrPtrNext;
      end
   end

   // Scan starting at the pointer; only a real grant moves it, dead-head retirement does not.
   always_comb begin : arbComb
      logic [1:0] idx;
      idx         = '0;
      w_rrPtrNext = r_rrPtr;
      w_grantSrc  = r_rrPtr;
      w_anyGrant  = 1'b0;
      w_grant     = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         idx = srcAdd(r_rrPtr, 2'(k));
         if (!w_anyGrant && w_eligible[idx]) begin
            w_anyGrant = 1'b1;
            w_grantSrc = src_e'(idx);
         end
      end
      if (w_anyGrant) begin
         w_grant[w_grantSrc] = 1'b1;
         w_rrPtrNext         = src_e'(srcAdd(w_grantSrc, 2'd1));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cdb      <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_anyGrant) begin
            r_cdb <= '{valid: 1'b1, robTag: w_head[w_grantSrc].robTag, pd: w_head[w_grantSrc].pd,
                       we: w_head[w_grantSrc].we, data: w_head[w_grantSrc].data};
         end else begin
            r_cdb.valid <= 1'b0;
         end
         if (|w_overflowPulse) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign bus.alu_full    = w_full[SRC_ALU];
   assign bus.b_full      = w_full[SRC_BR];
   assign bus.mem_full    = w_full[SRC_MEM];
   assign bus.cdb_valid   = r_cdb.valid;
   assign bus.cdb_rob_tag = r_cdb.robTag;
   assign bus.cdb_pd      = r_cdb.pd;
   assign bus.cdb_we      = r_cdb.we;
   assign bus.cdb_data    = r_cdb.data;
   assign bus.overflow    = r_overflow;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-based model predicts every CDB broadcast with the
// cycle it must appear in, and a negedge monitor checks the DUT against those predictions.
module tb_wb_arbiter;
   import wb_arbiter_pkg::*;

   localparam int DEPTH = 2;

   typedef struct packed {
      logic        valid;
      logic [4:0]  tag;
      logic [6:0]  pd;
      logic        we;
      logic [31:0] data;
   } src_t;

   typedef struct packed {
      logic        live;
      logic [4:0]  tag;
      logic [6:0]  pd;
      logic        we;
      logic [31:0] data;
   } mEntry_t;

   typedef struct packed {
      int unsigned stamp;
      logic [4:0]  tag;
      logic [6:0]  pd;
      logic        we;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic reset;

   wb_arbiter_if bus();

   wb_arbiter #(
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   src_t       stimSrc [3];
   logic       stimReset;
   logic       stimMisp;
   logic [4:0] stimMispTag;
   logic [4:0] stimRobHead;

   mEntry_t    mq [3][$];
   exp_t       expQ [$];
   int         rr;
   logic [2:0] expFull;
   logic       expOvf;

   function automatic int age(input logic [4:0] t);
      return (int'(t) - int'(stimRobHead) + 32) % 32;
   endfunction

   // Reference behaviour for one clock edge, expressed on whole-entry queues.
   task automatic modelStep();
      logic    hasHead [3];
      logic    accept  [3];
      mEntry_t h       [3];
      mEntry_t tmp;
      int      g;
      int      mispAge;
      int      s;
      if (stimReset) begin
         for (int i = 0; i < 3; i++) mq[i].delete();
         rr      = 0;
         expOvf  = 1'b0;
         expFull = '0;
         return;
      end
      mispAge = age(stimMispTag);
      for (int i = 0; i < 3; i++) begin
         if (stimMisp) begin
            for (int j = 0; j < mq[i].size(); j++) begin
               if (age(mq[i][j].tag) > mispAge) begin
                  tmp = mq[i][j];
                  tmp.live = 1'b0;
                  mq[i][j] = tmp;
               end
            end
         end
         if (stimSrc[i].valid && mq[i].size() >= DEPTH) expOvf = 1'b1;
         accept[i] = stimSrc[i].valid && (mq[i].size() < DEPTH) &&
                     !(stimMisp && age(stimSrc[i].tag) > mispAge);
         hasHead[i] = 1'b0;
         h[i] = '0;
         if (mq[i].size() > 0) begin
            h[i] = mq[i][0];
            hasHead[i] = 1'b1;
         end else if (accept[i]) begin
            h[i] = '{1'b1, stimSrc[i].tag, stimSrc[i].pd, stimSrc[i].we, stimSrc[i].data};
            hasHead[i] = 1'b1;
         end
      end
      g = -1;
      for (int k = 0; k < 3; k++) begin
         s = (rr + k) % 3;
         if (g < 0 && hasHead[s] && h[s].live) g = s;
      end
      if (g >= 0) begin
         expQ.push_back('{stamp: cyc + 1, tag: h[g].tag, pd: h[g].pd, we: h[g].we, data: h[g].data});
         rr = (g + 1) % 3;
      end
      for (int i = 0; i < 3; i++) begin
         if (accept[i]) mq[i].push_back('{1'b1, stimSrc[i].tag, stimSrc[i].pd, stimSrc[i].we, stimSrc[i].data});
         if (hasHead[i] && (i == g || !h[i].live)) void'(mq[i].pop_front());
         expFull[i] = (mq[i].size() == DEPTH);
      end
   endtask

   task automatic checkOutput();
      logic [2:0] gotFull;
      gotFull = {bus.mem_full, bus.b_full, bus.alu_full};
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (gotFull[i] !== expFull[i]) begin
            failures++;
            $display("[TB] FAIL fullFlag src=%0d cyc=%0d got=%b expected=%b", i, cyc, gotFull[i], expFull[i]);
         end
      end
      checks++;
      if (bus.overflow !== expOvf) begin
         failures++;
         $display("[TB] FAIL overflow cyc=%0d got=%b expected=%b", cyc, bus.overflow, expOvf);
      end
   endtask

   task automatic checkResetFields();
      checks++;
      if ({bus.cdb_valid, bus.cdb_rob_tag, bus.cdb_pd, bus.cdb_we, bus.cdb_data} !== 46'd0) begin
         failures++;
         $display("[TB] FAIL resetCdb got valid=%b tag=%0d pd=%0d we=%b data=%h expected all zero",
                  bus.cdb_valid, bus.cdb_rob_tag, bus.cdb_pd, bus.cdb_we, bus.cdb_data);
      end
   endtask

   task automatic applyStimulus();
      @(posedge clk);
      #1;
      checkOutput();
      reset              = stimReset;
      bus.alu_valid      = stimSrc[0].valid;
      bus.alu_rob_tag    = stimSrc[0].tag;
      bus.alu_pd         = stimSrc[0].pd;
      bus.alu_we         = stimSrc[0].we;
      bus.alu_result     = stimSrc[0].data;
      bus.b_valid        = stimSrc[1].valid;
      bus.b_rob_tag      = stimSrc[1].tag;
      bus.b_pd           = stimSrc[1].pd;
      bus.b_we           = stimSrc[1].we;
      bus.b_result       = stimSrc[1].data;
      bus.mem_valid      = stimSrc[2].valid;
      bus.mem_rob_tag    = stimSrc[2].tag;
      bus.mem_pd         = stimSrc[2].pd;
      bus.mem_we         = stimSrc[2].we;
      bus.mem_result     = stimSrc[2].data;
      bus.mispredict     = stimMisp;
      bus.mispredict_tag = stimMispTag;
      bus.rob_head       = stimRobHead;
      modelStep();
   endtask

   task automatic clearStim();
      for (int i = 0; i < 3; i++) stimSrc[i] = '0;
      stimReset   = 1'b0;
      stimMisp    = 1'b0;
      stimMispTag = '0;
   endtask

   task automatic setSrc(input int s, input logic [4:0] tag, input logic [6:0] pd,
                         input logic we, input logic [31:0] data);
      stimSrc[s] = '{valid: 1'b1, tag: tag, pd: pd, we: we, data: data};
   endtask

   task automatic randomSrc(input int s);
      setSrc(s, 5'($urandom), 7'($urandom), 1'($urandom), $urandom);
   endtask

   task automatic idle(input int n);
      clearStim();
      for (int i = 0; i < n; i++) applyStimulus();
   endtask

   task automatic doReset();
      clearStim();
      stimReset = 1'b1;
      applyStimulus();
      clearStim();
   endtask

   exp_t monE;
   always @(negedge clk) begin
      if (expQ.size() != 0 && expQ[0].stamp == cyc) begin
         monE = expQ.pop_front();
         checks++;
         if (bus.cdb_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL cdbMissing cyc=%0d got valid=%b expected tag=%0d", cyc, bus.cdb_valid, monE.tag);
         end else if ({bus.cdb_rob_tag, bus.cdb_pd, bus.cdb_we, bus.cdb_data} !==
                      {monE.tag, monE.pd, monE.we, monE.data}) begin
            failures++;
            $display("[TB] FAIL cdbFields cyc=%0d got tag=%0d pd=%0d we=%b data=%h expected tag=%0d pd=%0d we=%b data=%h",
                     cyc, bus.cdb_rob_tag, bus.cdb_pd, bus.cdb_we, bus.cdb_data,
                     monE.tag, monE.pd, monE.we, monE.data);
         end
      end else begin
         checks++;
         if (bus.cdb_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL cdbUnexpected cyc=%0d got valid=%b tag=%0d expected valid=0",
                     cyc, bus.cdb_valid, bus.cdb_rob_tag);
         end
      end
   end

   initial begin
      clearStim();
      stimRobHead = '0;
      rr          = 0;
      expFull     = '0;
      expOvf      = 1'b0;
      reset              = 1'b1;
      bus.alu_valid      = 1'b0;
      bus.b_valid        = 1'b0;
      bus.mem_valid      = 1'b0;
      bus.mispredict     = 1'b0;
      bus.mispredict_tag = '0;
      bus.rob_head       = '0;

      doReset();
      doReset();
      checkResetFields();

      $display("[TB] single ALU result");
      setSrc(0, 5'd3, 7'd40, 1'b1, 32'hDEAD_BEEF);
      applyStimulus();
      idle(3);

      $display("[TB] three sources at once");
      doReset();
      setSrc(0, 5'd4, 7'd10, 1'b1, 32'h1111_0000);
      setSrc(1, 5'd5, 7'd11, 1'b0, 32'h2222_0000);
      setSrc(2, 5'd6, 7'd12, 1'b1, 32'h3333_0000);
      applyStimulus();
      idle(4);

      $display("[TB] ALU and MEM streams, then BR joins");
      doReset();
      for (int n = 0; n < 16; n++) begin
         clearStim();
         if (mq[0].size() < DEPTH) randomSrc(0);
         if (mq[2].size() < DEPTH) randomSrc(2);
         if (n >= 8 && mq[1].size() < DEPTH) randomSrc(1);
         applyStimulus();
      end
      idle(6);

      $display("[TB] flush across tag wrap");
      doReset();
      stimRobHead = 5'd30;
      setSrc(0, 5'd31, 7'd20, 1'b1, 32'hAAAA_0031);
      setSrc(1, 5'd1,  7'd21, 1'b0, 32'hBBBB_0001);
      setSrc(2, 5'd2,  7'd22, 1'b1, 32'hCCCC_0002);
      applyStimulus();
      clearStim();
      stimMisp    = 1'b1;
      stimMispTag = 5'd1;
      applyStimulus();
      idle(5);

      $display("[TB] ALU overflow");
      doReset();
      stimRobHead = '0;
      for (int n = 0; n < 8; n++) begin
         clearStim();
         randomSrc(0);
         if (mq[1].size() < DEPTH) randomSrc(1);
         if (mq[2].size() < DEPTH) randomSrc(2);
         applyStimulus();
      end
      idle(8);
      doReset();
      idle(2);

      $display("[TB] reset mid-stream");
      for (int n = 0; n < 2; n++) begin
         clearStim();
         for (int s = 0; s < 3; s++) if (mq[s].size() < DEPTH) randomSrc(s);
         applyStimulus();
      end
      doReset();
      idle(3);

      $display("[TB] random traffic");
      for (int n = 0; n < 600; n++) begin
         clearStim();
         stimReset = ($urandom_range(199) == 0);
         if ($urandom_range(7) == 0) stimRobHead = 5'($urandom);
         stimMisp    = ($urandom_range(11) == 0);
         stimMispTag = 5'($urandom);
         for (int s = 0; s < 3; s++) begin
            if (mq[s].size() < DEPTH && $urandom_range(99) < 60) randomSrc(s);
         end
         applyStimulus();
      end
      idle(10);

      checks++;
      if (expQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL drain got pending=%0d expected pending=0", expQ.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, meaning per-source result buffer entries.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports alu_valid / b_valid / mem_valid  input  1 each  result presented this cycle by the ALU / branch / memory FU.
REQ-005 SHALL have ports alu_rob_tag / b_rob_tag / mem_rob_tag  input  5 each  ROB tag of that result.
REQ-006 SHALL have ports alu_pd / b_pd / mem_pd  input  7 each  destination physical register.
REQ-007 SHALL have ports alu_we / b_we / mem_we  input  1 each  result writes the PRF (0 = ROB completion only, e.g. store or branch without rd).
REQ-008 SHALL have ports alu_result / b_result / mem_result  input  32 each  result value.
REQ-009 SHALL have ports alu_full / b_full / mem_full  output  1 each  buffer holds FIFO_DEPTH entries; FU must not present valid.
REQ-010 SHALL have ports mispredict  input  1, mispredict_tag  input  5, rob_head  input  5  branch flush request and ROB reference point.
REQ-011 SHALL have ports cdb_valid  output  1, cdb_rob_tag  output  5, cdb_pd  output  7, cdb_we  output  1, cdb_data  output  32  single common-data-bus broadcast to PRF, ROB and reservation stations.
REQ-012 SHALL have port overflow  output  1  sticky error: a push arrived while that source was full.

Function
REQ-013 SHALL capture each valid input into its source FIFO in the same cycle; the result is broadcast on the CDB no earlier than the following cycle (minimum latency 1, registered outputs).
REQ-014 SHALL broadcast at most one result per cycle; cdb_* fields are registered and hold the granted FIFO head.
REQ-015 SHALL arbitrate round-robin over eligible sources in the order ALU, BR, MEM, starting after the last-granted source; after reset the pointer selects ALU first.
REQ-016 A source SHALL be eligible only when its FIFO head entry is valid.
REQ-017 *_full SHALL equal (count == FIFO_DEPTH) from registered count; a push while full SHALL be dropped and SHALL set overflow, even when the same FIFO pops that cycle.
REQ-018 Simultaneous push and pop on a non-full FIFO SHALL keep count unchanged and preserve FIFO order.
REQ-019 Age SHALL be (tag - rob_head) mod 32; an entry is younger than the mispredict when its age > (mispredict_tag - rob_head) mod 32; equal age (the branch itself) is kept.
REQ-020 On mispredict SHALL, in that cycle, clear the valid bit of every younger buffered entry, drop younger incoming pushes, and exclude them from the grant.
REQ-021 On mispredict, a younger result already in the cdb register SHALL NOT be re-driven: cdb_valid deasserts next cycle unless a surviving entry is granted.
REQ-022 An invalid (flushed) FIFO head SHALL be popped without broadcast in the cycle it is seen, one per FIFO per cycle, and SHALL NOT advance the round-robin pointer.
REQ-023 SHALL deassert cdb_valid in any cycle with no eligible source; other cdb_* fields are don't-care when cdb_valid = 0.
REQ-024 Pointers SHALL wrap modulo FIFO_DEPTH; ROB tag arithmetic SHALL wrap modulo 32.

Reset
REQ-025 On reset SHALL clear all FIFO counts, pointers and entry valids, set round-robin pointer to ALU, and drive cdb_valid, cdb_rob_tag, cdb_pd, cdb_we, cdb_data, overflow, *_full all to 0.
REQ-026 Reset SHALL override same-cycle pushes, pops and mispredict; inputs presented during reset are discarded.

Structure
REQ-027 The wb entry typedef (valid, rob_tag, pd, we, data) and the ROB-age compare function SHALL live in the shared package with the existing FU output types.
REQ-028 SHALL instantiate one sub-module wb_fifo (per-source buffer with per-entry flush mask) three times.

Verification
REQ-029 Single ALU push tag 3, pd 40, data 0xDEAD_BEEF at cycle N -> cdb_valid=1 with same fields at N+1 only.
REQ-030 All three sources valid in one cycle after reset -> broadcasts ALU, BR, MEM on three consecutive cycles.
REQ-031 Continuous ALU and MEM streams -> strict alternation ALU, MEM; BR never starved once valid.
REQ-032 rob_head=30, buffered tags 31, 1, 2, mispredict_tag=1 -> tags 31 and 1 broadcast, tag 2 never appears.
REQ-033 Two ALU pushes with no grant opportunity, third push -> alu_full=1, third dropped, overflow=1 until reset.
REQ-034 Reset asserted mid-stream with two entries buffered -> next cycle cdb_valid=0, counts 0, overflow=0.
